count_sequencer: RTL and testbench

//  Command-driven controller for the WIDTH-bit loadable up-counter (ports rst/ld/v/count).

---
 rtl/count_sequencer.sv | 119 +++++++++++
 tb/tb_count_sequencer.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/count_sequencer.sv
// Command-driven run controller for a loadable up-counter.
// A command preloads the counter with a start value and lets it advance a
// given number of cycles. The counter is then frozen and the run result is reported.
// The counter has no enable, so every "hold" is done by reloading its own count.
module count_sequencer #(
   parameter int unsigned WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             cmd_valid,
   output logic             cmd_ready,
   input  logic [WIDTH-1:0] cmd_start,
   input  logic [WIDTH-1:0] cmd_len,
   input  logic             abort,
   input  logic [WIDTH-1:0] cnt_q,
   output logic             cnt_ld,
   output logic [WIDTH-1:0] cnt_v,
   output logic             busy,
   output logic             done,
   output logic             aborted,
   output logic             wrapped,
   output logic [WIDTH-1:0] end_val
);

   typedef enum logic [1:0] {StIdle, StLoad, StRun, StDone} state_e;

   state_e           state_q, state_d;
   logic [WIDTH-1:0] start_q, start_d;
   logic [WIDTH-1:0] len_q, len_d;
   logic [WIDTH-1:0] rem_q, rem_d;
   logic [WIDTH-1:0] end_val_q, end_val_d;
   logic             aborted_q, aborted_d;
   logic             wrapped_q, wrapped_d;

   // Next-state and decoded outputs; default is "hold the counter where it is".
   always_comb begin
      state_d   = state_q;
      start_d   = start_q;
      len_d     = len_q;
      rem_d     = rem_q;
      end_val_d = end_val_q;
      aborted_d = aborted_q;
      wrapped_d = wrapped_q;
      cmd_ready = 1'b0;
      cnt_ld    = 1'b1;
      cnt_v     = cnt_q;
      busy      = 1'b1;
      done      = 1'b0;

      unique case (state_q)
         StIdle: begin
            cmd_ready = 1'b1;
            busy      = 1'b0;
            if (cmd_valid) begin
               start_d = cmd_start;
               len_d   = cmd_len;
               rem_d   = cmd_len;
               state_d = StLoad;
            end
         end
         StLoad: begin
            cnt_v     = start_q;
            aborted_d = 1'b0;
            wrapped_d = 1'b0;
            state_d   = (len_q != '0) ? StRun : StDone;
         end
         StRun: begin
            if (abort) begin
               // Abort beats the final increment: reload the current count instead.
               aborted_d = 1'b1;
               state_d   = StDone;
            end else begin
               cnt_ld = 1'b0;
               rem_d  = rem_q - WIDTH'(1);
               if (cnt_q == '1) begin
                  wrapped_d = 1'b1;
               end
               if (rem_q == WIDTH'(1)) begin
                  state_d = StDone;
               end
            end
         end
         StDone: begin
            done      = 1'b1;
            end_val_d = cnt_q;
            state_d   = StIdle;
         end
         default: begin
            state_d = StIdle;
         end
      endcase
   end

   // State and result registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= StIdle;
         start_q   <= '0;
         len_q     <= '0;
         rem_q     <= '0;
         end_val_q <= '0;
         aborted_q <= 1'b0;
         wrapped_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         start_q   <= start_d;
         len_q     <= len_d;
         rem_q     <= rem_d;
         end_val_q <= end_val_d;
         aborted_q <= aborted_d;
         wrapped_q <= wrapped_d;
      end
   end

   assign aborted = aborted_q;
   assign wrapped = wrapped_q;
   assign end_val = end_val_q;

endmodule

// File: tb/tb_count_sequencer.sv
// Self-checking bench for count_sequencer with a behavioural counter attached.
// Expected results come from run arithmetic: start + increments, overflow past 255,
// and accept-to-done latency.
module tb_count_sequencer;

   logic       clk;
   logic       rst;
   logic       cmd_valid;
   logic       cmd_ready;
   logic [7:0] cmd_start;
   logic [7:0] cmd_len;
   logic       abort;
   logic [7:0] cnt_q;
   logic       cnt_ld;
   logic [7:0] cnt_v;
   logic       busy;
   logic       done;
   logic       aborted;
   logic       wrapped;
   logic [7:0] end_val;

   int checks = 0;
   int errors = 0;

   count_sequencer #(.WIDTH(8)) dut (
      .clk       (clk),
      .rst       (rst),
      .cmd_valid (cmd_valid),
      .cmd_ready (cmd_ready),
      .cmd_start (cmd_start),
      .cmd_len   (cmd_len),
      .abort     (abort),
      .cnt_q     (cnt_q),
      .cnt_ld    (cnt_ld),
      .cnt_v     (cnt_v),
      .busy      (busy),
      .done      (done),
      .aborted   (aborted),
      .wrapped   (wrapped),
      .end_val   (end_val)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Loadable up-counter sharing clk/rst with the sequencer.
   always_ff @(posedge clk) begin
      if (rst)         cnt_q <= 8'h00;
      else if (cnt_ld) cnt_q <= cnt_v;
      else             cnt_q <= cnt_q + 8'h01;
   end

   // Issue one command at an IDLE negedge and follow it to completion.
   // ab = RUN cycle index (0-based) at which abort is raised, or -1 for none.
   // hold = keep cmd_valid high with the next command (ns, nl) for the whole run.
   // Returns at the negedge of the first IDLE cycle after done.
   task automatic run_cmd(input logic [7:0] s, input logic [7:0] l, input int ab,
                          input bit hold, input logic [7:0] ns, input logic [7:0] nl);
      int         inc, lat, cyc;
      bit         exp_ab, exp_wr, side_ok, seen;
      logic [7:0] exp_end;
      exp_ab  = (ab >= 0) && (ab < int'(l));
      inc     = exp_ab ? ab : int'(l);
      exp_end = 8'(int'(s) + inc);
      exp_wr  = (int'(s) + inc) > 255;
      lat     = exp_ab ? inc + 3 : inc + 2;

      checks++;
      if (cmd_ready !== 1'b1) begin
         errors++;
         $display("FAIL ready_before_cmd: got %b expected 1", cmd_ready);
      end
      cmd_valid = 1'b1;
      cmd_start = s;
      cmd_len   = l;
      @(negedge clk);
      if (hold) begin
         cmd_start = ns;
         cmd_len   = nl;
      end else begin
         cmd_valid = 1'(($urandom_range(0, 1)));
         cmd_start = 8'($urandom);
         cmd_len   = 8'($urandom);
      end
      cyc     = 1;
      side_ok = 1'b1;
      seen    = 1'b0;
      while (!seen && cyc <= 300) begin
         if (done === 1'b1) begin
            seen = 1'b1;
            checks++;
            if (cyc != lat) begin
               errors++;
               $display("FAIL latency s=%0h l=%0d ab=%0d: got %0d expected %0d", s, l, ab, cyc,
                        lat);
            end
            checks++;
            if (aborted !== exp_ab) begin
               errors++;
               $display("FAIL aborted s=%0h l=%0d ab=%0d: got %b expected %b", s, l, ab,
                        aborted, exp_ab);
            end
            checks++;
            if (wrapped !== exp_wr) begin
               errors++;
               $display("FAIL wrapped s=%0h l=%0d ab=%0d: got %b expected %b", s, l, ab,
                        wrapped, exp_wr);
            end
            checks++;
            if (cnt_q !== exp_end) begin
               errors++;
               $display("FAIL count_in_done s=%0h l=%0d: got %0h expected %0h", s, l, cnt_q,
                        exp_end);
            end
            cmd_valid = hold;
            abort     = 1'(($urandom_range(0, 1)));
         end else begin
            if (busy !== 1'b1 || cmd_ready !== 1'b0) side_ok = 1'b0;
            if (exp_ab && cyc == ab + 2) abort = 1'b1;
            else if (cyc == 1)           abort = 1'(($urandom_range(0, 1)));
            else                         abort = 1'b0;
            @(negedge clk);
            cyc++;
         end
      end
      checks++;
      if (!seen) begin
         errors++;
         $display("FAIL done_timeout s=%0h l=%0d: got no done expected done at %0d", s, l, lat);
         abort     = 1'b0;
         cmd_valid = 1'b0;
         return;
      end
      checks++;
      if (!side_ok) begin
         errors++;
         $display("FAIL busy_ready_during_run: got busy/ready wrong expected busy=1 ready=0");
      end
      @(negedge clk);
      abort = 1'b0;
      checks++;
      if (end_val !== exp_end) begin
         errors++;
         $display("FAIL end_val s=%0h l=%0d ab=%0d: got %0h expected %0h", s, l, ab, end_val,
                  exp_end);
      end
      checks++;
      if (cnt_q !== exp_end || done !== 1'b0 || cmd_ready !== 1'b1) begin
         errors++;
         $display("FAIL idle_after_done: got cnt=%0h done=%b ready=%b expected %0h 0 1", cnt_q,
                  done, cmd_ready, exp_end);
      end
   endtask

   task automatic test_reset();
      rst       = 1'b1;
      cmd_valid = 1'b1;
      cmd_start = 8'h33;
      cmd_len   = 8'h04;
      abort     = 1'b1;
      repeat (3) @(negedge clk);
      checks++;
      if (cmd_ready !== 1'b1 || busy !== 1'b0 || done !== 1'b0 || cnt_ld !== 1'b1) begin
         errors++;
         $display("FAIL reset_ctrl: got ready=%b busy=%b done=%b ld=%b expected 1 0 0 1",
                  cmd_ready, busy, done, cnt_ld);
      end
      checks++;
      if (aborted !== 1'b0 || wrapped !== 1'b0 || end_val !== 8'h00 || cnt_q !== 8'h00) begin
         errors++;
         $display("FAIL reset_regs: got ab=%b wr=%b end=%0h cnt=%0h expected 0 0 0 0", aborted,
                  wrapped, end_val, cnt_q);
      end
      rst       = 1'b0;
      cmd_valid = 1'b0;
      abort     = 1'b0;
      @(negedge clk);
      checks++;
      if (busy !== 1'b0 || cnt_q !== 8'h00) begin
         errors++;
         $display("FAIL reset_release: got busy=%b cnt=%0h expected 0 0", busy, cnt_q);
      end
   endtask

   task automatic test_directed();
      run_cmd(8'h05, 8'd3, -1, 1'b0, 8'h00, 8'h00);
      run_cmd(8'hFE, 8'd4, -1, 1'b0, 8'h00, 8'h00);
      run_cmd(8'h01, 8'hFF, -1, 1'b0, 8'h00, 8'h00);
      run_cmd(8'h30, 8'd5, 4, 1'b0, 8'h00, 8'h00);
   endtask

   task automatic test_len_zero();
      run_cmd(8'h10, 8'd0, -1, 1'b0, 8'h00, 8'h00);
      repeat (3) @(negedge clk);
      checks++;
      if (cnt_q !== 8'h10) begin
         errors++;
         $display("FAIL len0_hold: got %0h expected 10", cnt_q);
      end
   endtask

   task automatic test_abort();
      run_cmd(8'h00, 8'd10, 2, 1'b0, 8'h00, 8'h00);
      repeat (3) @(negedge clk);
      checks++;
      if (cnt_q !== 8'h02 || aborted !== 1'b1) begin
         errors++;
         $display("FAIL abort_hold: got cnt=%0h ab=%b expected 02 1", cnt_q, aborted);
      end
   endtask

   task automatic test_rst_mid_run();
      bit saw_done;
      cmd_valid = 1'b1;
      cmd_start = 8'h55;
      cmd_len   = 8'd20;
      @(negedge clk);
      cmd_valid = 1'b0;
      repeat (4) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      checks++;
      if (cmd_ready !== 1'b1 || busy !== 1'b0 || done !== 1'b0 || cnt_q !== 8'h00) begin
         errors++;
         $display("FAIL rst_mid_run: got ready=%b busy=%b done=%b cnt=%0h expected 1 0 0 00",
                  cmd_ready, busy, done, cnt_q);
      end
      rst      = 1'b0;
      saw_done = 1'b0;
      repeat (25) begin
         @(negedge clk);
         if (done === 1'b1) saw_done = 1'b1;
      end
      checks++;
      if (saw_done || cnt_q !== 8'h00) begin
         errors++;
         $display("FAIL rst_no_done: got done_seen=%b cnt=%0h expected 0 00", saw_done, cnt_q);
      end
      run_cmd(8'h07, 8'd6, -1, 1'b0, 8'h00, 8'h00);
   endtask

   task automatic test_back_to_back();
      run_cmd(8'h20, 8'd3, -1, 1'b1, 8'h40, 8'd2);
      run_cmd(8'h40, 8'd2, -1, 1'b0, 8'h00, 8'h00);
   endtask

   task automatic test_random();
      logic [7:0] s, l;
      int         ab;
      for (int i = 0; i < 40; i++) begin
         s  = ($urandom_range(0, 1) != 0) ? 8'($urandom_range(230, 255)) : 8'($urandom);
         l  = 8'($urandom_range(0, 24));
         ab = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, 26)) : -1;
         run_cmd(s, l, ab, 1'b0, 8'h00, 8'h00);
         repeat ($urandom_range(0, 2)) @(negedge clk);
      end
   endtask

   initial begin
      rst       = 1'b1;
      cmd_valid = 1'b0;
      cmd_start = 8'h00;
      cmd_len   = 8'h00;
      abort     = 1'b0;
      test_reset();
      test_directed();
      test_len_zero();
      test_abort();
      test_rst_mid_run();
      test_back_to_back();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
